// File: rtl/posit_addsub_if.sv
// Operand/result bundle for the posit add/sub unit with its ap_* block handshake.
// master drives the request side; slave is the arithmetic unit.
interface posit_addsub_if #(
   parameter int N = 32
);
   logic         ap_start;
   logic         op;
   logic [N-1:0] num1;
   logic [N-1:0] num2;
   logic         ap_idle;
   logic         ap_done;
   logic         ap_ready;
   logic [N-1:0] ap_return;
   logic         nar_flag;

   modport master (
      output ap_start, op, num1, num2,
      input  ap_idle, ap_done, ap_ready, ap_return, nar_flag
   );

   modport slave (
      input  ap_start, op, num1, num2,
      output ap_idle, ap_done, ap_ready, ap_return, nar_flag
   );
endinterface

// File: rtl/posit_addsub_unit.sv
// Multi-cycle posit<N,ES> adder/subtractor with NaR/zero bypass and saturation.
// Latency: start accepted at edge t, ap_done/ap_return valid in the sixth cycle after it.
// Backpressure: none; ap_start is only taken while ap_idle=1, otherwise ignored.
module posit_addsub_unit #(
   parameter int N   = 32,
   parameter int ES  = 2,
   parameter int LAT = 6
) (
   input  logic          ap_clk,
   input  logic          ap_rst,
   posit_addsub_if.slave io
);
   localparam int SW    = $clog2(N) + ES + 2;
   localparam int MW    = N + 3;               // hidden+fraction, two guard bits, sticky
   localparam int TW    = ES + N + 4;
   localparam int VW    = TW + N;
   localparam int MAXSC = (N - 2) << ES;
   localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

   typedef struct packed {
      logic          sgn;
      logic [SW-1:0] scale;
      logic [N-1:0]  mant;
   } opnd_t;

   typedef enum logic [$clog2(LAT+1)-1:0] {
      S_IDLE, S_DECODE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t        state;
   logic [N-1:0]  a_word, b_word, spc_word;
   opnd_t         op_a, op_b;
   logic          spc, spc_nar;
   logic          al_sub, al_sgn, ad_sgn, nm_sgn, nm_zero;
   logic [SW-1:0] al_scale, ad_scale, nm_scale;
   logic [MW-1:0] al_va, al_vb;
   logic [MW:0]   ad_sum;
   logic [N+1:0]  nm_frac;

   // Caller guarantees p is neither zero nor NaR.
   function automatic opnd_t decode(input logic [N-1:0] p);
      opnd_t        o;
      logic [N-2:0] body, rem;
      logic         r, run;
      int           m, k, e;
      body = p[N-1] ? -p[N-2:0] : p[N-2:0];
      r    = body[N-2];
      m    = 0;
      run  = 1'b1;
      for (int i = N - 2; i >= 0; i--) begin
         if (run && body[i] == r) m++;
         else run = 1'b0;
      end
      k       = r ? m - 1 : -m;
      rem     = body << (m + 1);
      e       = int'(rem >> (N - 1 - ES));
      o.sgn   = p[N-1];
      o.scale = SW'((k <<< ES) + e);
      o.mant  = {1'b1, rem << ES};
      return o;
   endfunction

   logic [MW-1:0] va_c, vb_c;
   logic          sgn_c, sub_c;
   logic [SW-1:0] scale_c;

   always_comb begin
      opnd_t        big, sml;
      logic [N+1:0] ext, shf;
      logic         stk;
      int           d;
      if (($signed(op_a.scale) > $signed(op_b.scale)) ||
          (op_a.scale == op_b.scale && op_a.mant >= op_b.mant)) begin
         big = op_a;
         sml = op_b;
      end else begin
         big = op_b;
         sml = op_a;
      end
      d   = int'($signed(big.scale)) - int'($signed(sml.scale));
      ext = {sml.mant, 2'b00};
      shf = '0;
      stk = 1'b1;
      if (d < N + 2) begin
         shf = ext >> d;
         stk = |(ext & ~({(N+2){1'b1}} << d));
      end
      va_c    = {big.mant, 3'b000};
      vb_c    = {shf, stk};
      sgn_c   = big.sgn;
      sub_c   = big.sgn ^ sml.sgn;
      scale_c = big.scale;
   end

   logic [MW:0] sum_c;
   assign sum_c = al_sub ? ({1'b0, al_va} - {1'b0, al_vb}) : ({1'b0, al_va} + {1'b0, al_vb});

   logic [MW-1:0] mant_n;
   logic [SW-1:0] scale_n;

   always_comb begin
      int lz;
      lz = 0;
      for (int i = 0; i < MW; i++) begin
         if (ad_sum[i]) lz = MW - 1 - i;
      end
      if (ad_sum[MW]) begin
         mant_n  = ad_sum[MW:1] | {{(MW-1){1'b0}}, ad_sum[0]};
         scale_n = ad_scale + SW'(1);
      end else begin
         mant_n  = ad_sum[MW-1:0] << lz;
         scale_n = ad_scale - SW'(lz);
      end
   end

   logic [N-1:0] res_c;

   always_comb begin
      int            sc, k, e, sh;
      logic [TW-1:0] v0;
      logic [VW-1:0] vs;
      logic [N-2:0]  body;
      logic          guard, stk, rnd;
      sc = int'($signed(nm_scale));
      k  = sc >>> ES;
      e  = sc - (k <<< ES);
      sh = (k >= 0) ? k : -k - 1;
      // Regime seeded as 10/01 then arithmetically shifted to its run length.
      v0 = (TW'((k >= 0) ? 2 : 1) << (ES + N + 2)) | (TW'(e) << (N + 2)) | TW'(nm_frac);
      vs = $signed({v0, {N{1'b0}}}) >>> sh;
      body  = vs[VW-1 -: N-1];
      guard = vs[VW-N];
      stk   = |vs[VW-N-1:0];
      rnd   = guard & (stk | body[0]);
      if (sc > MAXSC)       body = '1;
      else if (sc < -MAXSC) body = {{(N-2){1'b0}}, 1'b1};
      else                  body = body + {{(N-2){1'b0}}, rnd};
      res_c = nm_sgn ? -{1'b0, body} : {1'b0, body};
      if (nm_zero) res_c = '0;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state        <= S_IDLE;
         a_word       <= '0;
         b_word       <= '0;
         op_a         <= '0;
         op_b         <= '0;
         spc          <= 1'b0;
         spc_nar      <= 1'b0;
         spc_word     <= '0;
         al_sub       <= 1'b0;
         al_sgn       <= 1'b0;
         al_scale     <= '0;
         al_va        <= '0;
         al_vb        <= '0;
         ad_sgn       <= 1'b0;
         ad_scale     <= '0;
         ad_sum       <= '0;
         nm_sgn       <= 1'b0;
         nm_zero      <= 1'b0;
         nm_scale     <= '0;
         nm_frac      <= '0;
         io.ap_idle   <= 1'b1;
         io.ap_done   <= 1'b0;
         io.ap_ready  <= 1'b0;
         io.ap_return <= '0;
         io.nar_flag  <= 1'b0;
      end else begin
         io.ap_done  <= 1'b0;
         io.ap_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               if (io.ap_start) begin
                  a_word     <= io.num1;
                  b_word     <= io.op ? -io.num2 : io.num2;
                  io.ap_idle <= 1'b0;
                  state      <= S_DECODE;
               end
            end
            S_DECODE: begin
               op_a     <= decode(a_word);
               op_b     <= decode(b_word);
               spc      <= 1'b1;
               spc_nar  <= 1'b0;
               spc_word <= '0;
               if (a_word == NAR || b_word == NAR) begin
                  spc_nar  <= 1'b1;
                  spc_word <= NAR;
               end else if (a_word == '0) begin
                  spc_word <= b_word;
               end else if (b_word == '0) begin
                  spc_word <= a_word;
               end else begin
                  spc <= 1'b0;
               end
               state <= S_ALIGN;
            end
            S_ALIGN: begin
               al_va    <= va_c;
               al_vb    <= vb_c;
               al_sgn   <= sgn_c;
               al_sub   <= sub_c;
               al_scale <= scale_c;
               state    <= S_ADD;
            end
            S_ADD: begin
               ad_sum   <= sum_c;
               ad_sgn   <= al_sgn;
               ad_scale <= al_scale;
               state    <= S_NORM;
            end
            S_NORM: begin
               nm_frac  <= mant_n[N+1:0];
               nm_zero  <= ~mant_n[MW-1];
               nm_scale <= scale_n;
               nm_sgn   <= ad_sgn;
               state    <= S_ROUND;
            end
            S_ROUND: begin
               io.ap_return <= spc ? spc_word : res_c;
               io.nar_flag  <= spc & spc_nar;
               io.ap_done   <= 1'b1;
               io.ap_ready  <= 1'b1;
               state        <= S_DONE;
            end
            S_DONE: begin
               io.ap_idle <= 1'b1;
               state      <= S_IDLE;
            end
            default: begin
               io.ap_idle <= 1'b1;
               state      <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_posit_addsub_unit.sv
// Directed checks of posit<32,2> add/sub: arithmetic, specials, saturation, rounding, handshake, reset.
module tb_posit_addsub_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   posit_addsub_if #(.N(32)) io ();
   posit_addsub_unit #(.N(32), .ES(2), .LAT(6)) dut (.ap_clk(clk), .ap_rst(rst), .io(io));

   always #5 clk = ~clk;

   // Launch one operation from IDLE, scramble the operands after acceptance, wait for ap_done.
   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic nar, output logic rdy, output int lat);
      io.ap_start = 1'b1;
      io.op       = op;
      io.num1     = a;
      io.num2     = b;
      @(posedge clk); #1;
      io.ap_start = 1'b0;
      io.op       = ~op;
      io.num1     = ~a;
      io.num2     = ~b;
      lat = 1;
      while (io.ap_done !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      res = io.ap_return;
      nar = io.nar_flag;
      rdy = io.ap_ready;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (io.ap_idle !== 1'b1)    begin bad++; $display("FAIL reset ap_idle: got %b want 1", io.ap_idle); end
      total++; if (io.ap_done !== 1'b0)    begin bad++; $display("FAIL reset ap_done: got %b want 0", io.ap_done); end
      total++; if (io.ap_ready !== 1'b0)   begin bad++; $display("FAIL reset ap_ready: got %b want 0", io.ap_ready); end
      total++; if (io.ap_return !== 32'h0) begin bad++; $display("FAIL reset ap_return: got %h want 0", io.ap_return); end
      total++; if (io.nar_flag !== 1'b0)   begin bad++; $display("FAIL reset nar_flag: got %b want 0", io.nar_flag); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_sub();
      logic        op_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] a_t  [5] = '{32'h40000000, 32'h40000000, 32'h48000000, 32'hC0000000, 32'h40000000};
      logic [31:0] b_t  [5] = '{32'h40000000, 32'h38000000, 32'h40000000, 32'hC0000000, 32'h48000000};
      logic [31:0] e_t  [5] = '{32'h48000000, 32'h44000000, 32'h40000000, 32'hB8000000, 32'hC0000000};
      logic [31:0] res;
      logic        nar, rdy;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         run_op(op_t[i], a_t[i], b_t[i], res, nar, rdy, lat);
         total++; if (res !== e_t[i]) begin bad++; $display("FAIL add_sub[%0d] result: got %h want %h", i, res, e_t[i]); end
         total++; if (nar !== 1'b0)   begin bad++; $display("FAIL add_sub[%0d] nar_flag: got %b want 0", i, nar); end
         total++; if (lat !== 6)      begin bad++; $display("FAIL add_sub[%0d] latency: got %0d want 6", i, lat); end
         total++; if (rdy !== 1'b1)   begin bad++; $display("FAIL add_sub[%0d] ap_ready: got %b want 1", i, rdy); end
      end
   endtask

   task automatic test_specials();
      logic        op_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] a_t  [6] = '{32'h40000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h40000000, 32'h40000000};
      logic [31:0] b_t  [6] = '{32'hC0000000, 32'h40000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h40000000};
      logic [31:0] e_t  [6] = '{32'h00000000, 32'h80000000, 32'h80000000, 32'hC0000000, 32'h40000000, 32'h00000000};
      logic        n_t  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] res;
      logic        nar, rdy;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         run_op(op_t[i], a_t[i], b_t[i], res, nar, rdy, lat);
         total++; if (res !== e_t[i]) begin bad++; $display("FAIL special[%0d] result: got %h want %h", i, res, e_t[i]); end
         total++; if (nar !== n_t[i]) begin bad++; $display("FAIL special[%0d] nar_flag: got %b want %b", i, nar, n_t[i]); end
         total++; if (lat !== 6)      begin bad++; $display("FAIL special[%0d] latency: got %0d want 6", i, lat); end
      end
   endtask

   task automatic test_saturation();
      logic        op_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] a_t  [4] = '{32'h7FFFFFFF, 32'h00000001, 32'h00000001, 32'h80000001};
      logic [31:0] b_t  [4] = '{32'h7FFFFFFF, 32'h00000001, 32'h00000001, 32'h80000001};
      logic [31:0] e_t  [4] = '{32'h7FFFFFFF, 32'h00000000, 32'h00000001, 32'h80000001};
      logic [31:0] res;
      logic        nar, rdy;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(op_t[i], a_t[i], b_t[i], res, nar, rdy, lat);
         total++; if (res !== e_t[i]) begin bad++; $display("FAIL saturate[%0d] result: got %h want %h", i, res, e_t[i]); end
         total++; if (nar !== 1'b0)   begin bad++; $display("FAIL saturate[%0d] nar_flag: got %b want 0", i, nar); end
      end
   endtask

   task automatic test_rounding();
      logic [31:0] a_t [3] = '{32'h40000000, 32'h40000001, 32'h40000000};
      logic [31:0] b_t [3] = '{32'h00800000, 32'h00800000, 32'h00000001};
      logic [31:0] e_t [3] = '{32'h40000000, 32'h40000002, 32'h40000000};
      logic [31:0] res;
      logic        nar, rdy;
      int          lat;
      for (int i = 0; i < 3; i++) begin
         run_op(1'b0, a_t[i], b_t[i], res, nar, rdy, lat);
         total++; if (res !== e_t[i]) begin bad++; $display("FAIL round[%0d] result: got %h want %h", i, res, e_t[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int done_at [$];
      io.ap_start = 1'b1;
      io.op       = 1'b0;
      io.num1     = 32'h40000000;
      io.num2     = 32'h40000000;
      for (int c = 1; c <= 21; c++) begin
         @(posedge clk); #1;
         if (io.ap_done === 1'b1) begin
            done_at.push_back(c);
            total++;
            if (io.ap_return !== 32'h48000000) begin
               bad++; $display("FAIL b2b result at cycle %0d: got %h want 48000000", c, io.ap_return);
            end
         end
      end
      io.ap_start = 1'b0;
      total++;
      if (done_at.size() !== 3) begin
         bad++; $display("FAIL b2b done count: got %0d want 3", done_at.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            total++;
            if (done_at[j] !== 6 + 7 * j) begin
               bad++; $display("FAIL b2b done[%0d] cycle: got %0d want %0d", j, done_at[j], 6 + 7 * j);
            end
         end
      end
      @(posedge clk); #1;
      total++; if (io.ap_idle !== 1'b1) begin bad++; $display("FAIL b2b idle after: got %b want 1", io.ap_idle); end
   endtask

   task automatic test_reset_mid_op();
      int n_done = 0;
      io.ap_start = 1'b1;
      io.op       = 1'b0;
      io.num1     = 32'h40000000;
      io.num2     = 32'h38000000;
      @(posedge clk); #1;
      io.ap_start = 1'b0;
      @(posedge clk); #1;
      total++; if (io.ap_idle !== 1'b0) begin bad++; $display("FAIL midrst busy: got ap_idle=%b want 0", io.ap_idle); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (io.ap_idle !== 1'b1)    begin bad++; $display("FAIL midrst ap_idle: got %b want 1", io.ap_idle); end
      total++; if (io.ap_return !== 32'h0) begin bad++; $display("FAIL midrst ap_return: got %h want 0", io.ap_return); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (io.ap_done === 1'b1) n_done++;
      end
      total++; if (n_done !== 0)        begin bad++; $display("FAIL midrst stray ap_done: got %0d want 0", n_done); end
      total++; if (io.ap_idle !== 1'b1) begin bad++; $display("FAIL midrst idle after: got %b want 1", io.ap_idle); end
   endtask

   initial begin
      io.ap_start = 1'b0;
      io.op       = 1'b0;
      io.num1     = '0;
      io.num2     = '0;
      test_reset();
      test_add_sub();
      test_specials();
      test_saturation();
      test_rounding();
      test_back_to_back();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
